// File: rtl/hls_handshake_perf_monitor.sv
// rtl/hls_handshake_perf_monitor.sv - per-channel HLS ap_* handshake performance counters
// Each channel runs an IDLE/BUSY/WAIT_CONT tracker; counters are read back through a registered mux.
module hls_handshake_perf_monitor #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 32,
  parameter  int LAT_W  = 24,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              finish,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              frozen
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, WAIT_CONT = 2'd2} state_t;

  state_t           state    [NUM_CH];
  state_t           state_n  [NUM_CH];
  logic [LAT_W-1:0] lat      [NUM_CH];
  logic [LAT_W-1:0] lat_n    [NUM_CH];
  logic [LAT_W-1:0] lat_inc  [NUM_CH];
  logic [LAT_W-1:0] lat_last [NUM_CH];
  logic [LAT_W-1:0] lat_last_n [NUM_CH];
  logic [LAT_W-1:0] lat_min  [NUM_CH];
  logic [LAT_W-1:0] lat_min_n [NUM_CH];
  logic [LAT_W-1:0] lat_max  [NUM_CH];
  logic [LAT_W-1:0] lat_max_n [NUM_CH];
  logic [LAT_W-1:0] rec_val  [NUM_CH];
  logic             rec      [NUM_CH];
  logic [CNT_W-1:0] txn      [NUM_CH];
  logic [CNT_W-1:0] txn_n    [NUM_CH];
  logic [CNT_W-1:0] busy     [NUM_CH];
  logic [CNT_W-1:0] busy_n   [NUM_CH];
  logic [CNT_W-1:0] stall    [NUM_CH];
  logic [CNT_W-1:0] stall_n  [NUM_CH];
  logic [CNT_W-1:0] ovl      [NUM_CH];
  logic [CNT_W-1:0] ovl_n    [NUM_CH];
  logic [CNT_W-1:0] rd_mux;
  logic             active;

  function automatic logic [CNT_W-1:0] inc_c(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LAT_W-1:0] inc_l(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + LAT_W'(1);
  endfunction

  assign active = enable & ~frozen;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_n[c]    = state[c];
      lat_n[c]      = lat[c];
      lat_inc[c]    = inc_l(lat[c]);
      lat_last_n[c] = lat_last[c];
      lat_min_n[c]  = lat_min[c];
      lat_max_n[c]  = lat_max[c];
      txn_n[c]      = txn[c];
      busy_n[c]     = busy[c];
      stall_n[c]    = stall[c];
      ovl_n[c]      = ovl[c];
      rec[c]        = 1'b0;
      rec_val[c]    = '0;
      if (active) begin
        case (state[c])
          IDLE: begin
            if (ap_start[c]) begin
              busy_n[c] = inc_c(busy[c]);
              lat_n[c]  = LAT_W'(1);
              if (ap_done[c] && ap_continue[c]) begin
                rec[c]     = 1'b1;
                rec_val[c] = LAT_W'(1);
                txn_n[c]   = inc_c(txn[c]);
              end else if (ap_done[c]) begin
                stall_n[c] = inc_c(stall[c]);
                state_n[c] = WAIT_CONT;
              end else begin
                state_n[c] = BUSY;
              end
            end
          end
          BUSY: begin
            busy_n[c] = inc_c(busy[c]);
            lat_n[c]  = lat_inc[c];
            if (ap_done[c] && ap_continue[c]) begin
              rec[c]     = 1'b1;
              rec_val[c] = lat_inc[c];
              txn_n[c]   = inc_c(txn[c]);
              // back-to-back start restarts latency for the next transaction
              if (ap_start[c]) lat_n[c] = LAT_W'(1);
              else             state_n[c] = IDLE;
            end else if (ap_done[c]) begin
              stall_n[c] = inc_c(stall[c]);
              state_n[c] = WAIT_CONT;
            end else if (ap_start[c] && ap_ready[c]) begin
              ovl_n[c] = inc_c(ovl[c]);
            end
          end
          WAIT_CONT: begin
            busy_n[c] = inc_c(busy[c]);
            lat_n[c]  = lat_inc[c];
            if (ap_continue[c]) begin
              rec[c]     = 1'b1;
              rec_val[c] = lat_inc[c];
              txn_n[c]   = inc_c(txn[c]);
              state_n[c] = IDLE;
            end else begin
              stall_n[c] = inc_c(stall[c]);
            end
          end
          default: state_n[c] = IDLE;
        endcase
      end
      if (rec[c]) begin
        lat_last_n[c] = rec_val[c];
        if (rec_val[c] < lat_min[c]) lat_min_n[c] = rec_val[c];
        if (rec_val[c] > lat_max[c]) lat_max_n[c] = rec_val[c];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (32'(rd_ch) < NUM_CH) begin
      case (rd_sel)
        3'd0: rd_mux = txn[rd_ch];
        3'd1: rd_mux = busy[rd_ch];
        3'd2: rd_mux = stall[rd_ch];
        3'd3: rd_mux = CNT_W'(lat_last[rd_ch]);
        3'd4: rd_mux = CNT_W'(lat_min[rd_ch]);
        3'd5: rd_mux = CNT_W'(lat_max[rd_ch]);
        3'd6: rd_mux = ovl[rd_ch];
        default: rd_mux = CNT_W'({frozen, (txn[rd_ch] != '0), 2'(state[rd_ch])});
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      frozen   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]    <= IDLE;
        lat[c]      <= '0;
        lat_last[c] <= '0;
        lat_min[c]  <= '1;
        lat_max[c]  <= '0;
        txn[c]      <= '0;
        busy[c]     <= '0;
        stall[c]    <= '0;
        ovl[c]      <= '0;
      end
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_mux;
      if (clear) begin
        frozen <= 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          state[c]    <= IDLE;
          lat[c]      <= '0;
          lat_last[c] <= '0;
          lat_min[c]  <= '1;
          lat_max[c]  <= '0;
          txn[c]      <= '0;
          busy[c]     <= '0;
          stall[c]    <= '0;
          ovl[c]      <= '0;
        end
      end else begin
        frozen <= frozen | finish;
        for (int c = 0; c < NUM_CH; c++) begin
          state[c]    <= state_n[c];
          lat[c]      <= lat_n[c];
          lat_last[c] <= lat_last_n[c];
          lat_min[c]  <= lat_min_n[c];
          lat_max[c]  <= lat_max_n[c];
          txn[c]      <= txn_n[c];
          busy[c]     <= busy_n[c];
          stall[c]    <= stall_n[c];
          ovl[c]      <= ovl_n[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_hls_handshake_perf_monitor.sv
// tb/tb_hls_handshake_perf_monitor.sv - directed and random checks of two monitor configurations
// Latency is modelled from per-transaction start timestamps on an active-cycle clock.
module tb_hls_handshake_perf_monitor;
  logic        clock = 1'b0;
  logic        reset, enable, clear, finish, rd_req;
  logic [2:0]  ap_start, ap_ready, ap_done, ap_continue;
  logic [1:0]  rd_ch;
  logic [2:0]  rd_sel;
  logic        rd_valid_a, rd_valid_b, frozen_a, frozen_b;
  logic [15:0] rd_data_a;
  logic [3:0]  rd_data_b;

  always #5 clock = ~clock;

  hls_handshake_perf_monitor #(.NUM_CH(3), .CNT_W(16), .LAT_W(8)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_valid(rd_valid_a), .rd_data(rd_data_a), .frozen(frozen_a));

  hls_handshake_perf_monitor #(.NUM_CH(2), .CNT_W(4), .LAT_W(4)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .finish(finish),
    .ap_start(ap_start[1:0]), .ap_ready(ap_ready[1:0]), .ap_done(ap_done[1:0]),
    .ap_continue(ap_continue[1:0]),
    .rd_req(rd_req), .rd_ch(rd_ch[0]), .rd_sel(rd_sel),
    .rd_valid(rd_valid_b), .rd_data(rd_data_b), .frozen(frozen_b));

  int     vectors = 0;
  int     errors  = 0;
  int     nch   [2] = '{3, 2};
  longint cap_c [2] = '{65535, 15};
  longint cap_l [2] = '{255, 15};
  int     m_st  [2][3];
  longint m_t0  [2][3];
  longint m_txn [2][3], m_busy [2][3], m_stall [2][3], m_ovl [2][3];
  longint m_last[2][3], m_min  [2][3], m_max   [2][3];
  longint m_act [2];
  bit     m_frz [2];

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sinc(input longint v, input longint cap);
    return (v >= cap) ? cap : v + 1;
  endfunction

  task automatic model_clear(input int d);
    for (int c = 0; c < 3; c++) begin
      m_st[d][c] = 0; m_t0[d][c] = 0;
      m_txn[d][c] = 0; m_busy[d][c] = 0; m_stall[d][c] = 0; m_ovl[d][c] = 0;
      m_last[d][c] = 0; m_min[d][c] = cap_l[d]; m_max[d][c] = 0;
    end
    m_act[d] = 0;
    m_frz[d] = 0;
  endtask

  task automatic record(input int d, input int c, input longint v);
    m_last[d][c] = v;
    if (v < m_min[d][c]) m_min[d][c] = v;
    if (v > m_max[d][c]) m_max[d][c] = v;
    m_txn[d][c] = sinc(m_txn[d][c], cap_c[d]);
  endtask

  task automatic chan_step(input int d, input int c);
    longint a, lat;
    bit s, r, dn, ct;
    a = m_act[d];
    s = ap_start[c]; r = ap_ready[c]; dn = ap_done[c]; ct = ap_continue[c];
    lat = a - m_t0[d][c] + 1;
    if (lat > cap_l[d]) lat = cap_l[d];
    if (m_st[d][c] == 0) begin
      if (s) begin
        m_busy[d][c] = sinc(m_busy[d][c], cap_c[d]);
        m_t0[d][c] = a;
        if (dn && ct) record(d, c, 1);
        else if (dn) begin m_stall[d][c] = sinc(m_stall[d][c], cap_c[d]); m_st[d][c] = 2; end
        else m_st[d][c] = 1;
      end
    end else if (m_st[d][c] == 1) begin
      m_busy[d][c] = sinc(m_busy[d][c], cap_c[d]);
      if (dn && ct) begin
        record(d, c, lat);
        if (s) m_t0[d][c] = a; else m_st[d][c] = 0;
      end else if (dn) begin
        m_stall[d][c] = sinc(m_stall[d][c], cap_c[d]);
        m_st[d][c] = 2;
      end else if (s && r) m_ovl[d][c] = sinc(m_ovl[d][c], cap_c[d]);
    end else begin
      m_busy[d][c] = sinc(m_busy[d][c], cap_c[d]);
      if (ct) begin record(d, c, lat); m_st[d][c] = 0; end
      else m_stall[d][c] = sinc(m_stall[d][c], cap_c[d]);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (clear) model_clear(d);
      else begin
        if (enable && !m_frz[d]) begin
          m_act[d]++;
          for (int c = 0; c < nch[d]; c++) chan_step(d, c);
        end
        if (finish) m_frz[d] = 1;
      end
    end
  endtask

  function automatic longint expect_rd(input int d, input int ch, input int sel);
    if (ch >= nch[d]) return 0;
    case (sel)
      0: return m_txn[d][ch];
      1: return m_busy[d][ch];
      2: return m_stall[d][ch];
      3: return m_last[d][ch];
      4: return m_min[d][ch];
      5: return m_max[d][ch];
      6: return m_ovl[d][ch];
      default: return (longint'(m_frz[d]) << 3) | (longint'(m_txn[d][ch] != 0) << 2) | m_st[d][ch];
    endcase
  endfunction

  task automatic step();
    bit     pend;
    longint ea, eb;
    pend = rd_req;
    ea = expect_rd(0, int'(rd_ch), int'(rd_sel));
    eb = expect_rd(1, int'(rd_ch[0]), int'(rd_sel));
    model_step();
    @(posedge clock); #1;
    check("rd_valid_a", rd_valid_a, pend);
    check("rd_valid_b", rd_valid_b, pend);
    check("frozen_a", frozen_a, m_frz[0]);
    check("frozen_b", frozen_b, m_frz[1]);
    if (pend) begin
      check("rd_data_a", rd_data_a, ea);
      check("rd_data_b", rd_data_b, eb);
    end
  endtask

  task automatic rd_chk(input string tag, input int ch, input int sel, input longint exp);
    rd_req = 1'b1; rd_ch = 2'(ch); rd_sel = 3'(sel);
    step();
    rd_req = 1'b0;
    check(tag, rd_data_a, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clear = 1'b0; finish = 1'b0; rd_req = 1'b0;
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
    rd_ch = '0; rd_sel = '0;
    model_clear(0); model_clear(1);
    #12;
    reset = 1'b0;
    check("rst_rd_valid", rd_valid_a, 0);
    check("rst_rd_data", rd_data_a, 0);
    check("rst_frozen", frozen_a, 0);
    rd_chk("rst_lat_min", 0, 4, 255);
    rd_chk("rst_status", 2, 7, 0);

    // ch0: 5-cycle transaction
    ap_start[0] = 1'b1; step(); ap_start[0] = 1'b0;
    idle(3);
    ap_done[0] = 1'b1; step(); ap_done[0] = 1'b0;
    rd_chk("c0_txn", 0, 0, 1);
    rd_chk("c0_last", 0, 3, 5);
    rd_chk("c0_min", 0, 4, 5);
    rd_chk("c0_max", 0, 5, 5);
    rd_chk("c0_busy", 0, 1, 5);
    rd_chk("c0_stall", 0, 2, 0);

    // ch1: done with continue held low for 4 cycles
    ap_start[1] = 1'b1; step(); ap_start[1] = 1'b0;
    idle(2);
    ap_done[1] = 1'b1; ap_continue[1] = 1'b0; step(); ap_done[1] = 1'b0;
    idle(2);
    rd_chk("c1_status_hold", 1, 7, 2);
    ap_continue[1] = 1'b1; step();
    rd_chk("c1_stall", 1, 2, 4);
    rd_chk("c1_last", 1, 3, 8);
    rd_chk("c1_busy", 1, 1, 8);

    // ch2: pipelined starts
    for (int i = 0; i < 7; i++) begin
      ap_start[2] = (i < 6); ap_ready[2] = (i < 6); ap_done[2] = (i >= 4);
      step();
    end
    ap_start[2] = 1'b0; ap_ready[2] = 1'b0; ap_done[2] = 1'b0;
    rd_chk("c2_ovl", 2, 6, 3);
    rd_chk("c2_txn", 2, 0, 3);
    rd_chk("c2_max", 2, 5, 5);

    // ch0: latencies 7 then 3
    ap_start[0] = 1'b1; step(); ap_start[0] = 1'b0;
    idle(5);
    ap_done[0] = 1'b1; step(); ap_done[0] = 1'b0;
    ap_start[0] = 1'b1; step(); ap_start[0] = 1'b0;
    idle(1);
    ap_done[0] = 1'b1; step(); ap_done[0] = 1'b0;
    rd_chk("c0_last2", 0, 3, 3);
    rd_chk("c0_min2", 0, 4, 3);
    rd_chk("c0_max2", 0, 5, 7);
    rd_chk("oob_ch", 3, 0, 0);

    // finish freezes, clear restores
    finish = 1'b1; ap_start[0] = 1'b1; ap_done[0] = 1'b1; step();
    finish = 1'b0; idle(3);
    ap_start[0] = 1'b0; ap_done[0] = 1'b0;
    rd_chk("frz_txn", 0, 0, 4);
    check("frz_flag", frozen_a, 1);
    clear = 1'b1; step(); clear = 1'b0;
    rd_chk("clr_txn", 0, 0, 0);
    rd_chk("clr_lat_min", 0, 4, 255);
    check("clr_frozen", frozen_a, 0);

    // 20 zero-latency transactions saturate the 4-bit counter
    ap_start[0] = 1'b1; ap_done[0] = 1'b1;
    idle(20);
    ap_start[0] = 1'b0; ap_done[0] = 1'b0;
    rd_chk("txn_20_a", 0, 0, 20);
    check("sat_b", rd_data_b, 15);

    for (int i = 0; i < 4000; i++) begin
      ap_start    = 3'($urandom_range(7)) & {3{$urandom_range(2) == 0}};
      ap_ready    = 3'($urandom_range(7));
      for (int c = 0; c < 3; c++) begin
        ap_done[c]     = ($urandom_range(3) == 0);
        ap_continue[c] = ($urandom_range(3) != 0);
      end
      enable = ($urandom_range(9) != 0);
      finish = ($urandom_range(999) == 0);
      clear  = ($urandom_range(399) == 0);
      rd_req = $urandom_range(1);
      rd_ch  = 2'($urandom_range(3));
      rd_sel = 3'($urandom_range(7));
      step();
    end
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
    enable = 1'b1; finish = 1'b0; clear = 1'b0; rd_req = 1'b0;
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < 8; s++) begin
        rd_req = 1'b1; rd_ch = 2'(c); rd_sel = 3'(s); step();
      end
    rd_req = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;

    // asynchronous reset mid-transaction
    ap_start[0] = 1'b1; step(); ap_start[0] = 1'b0;
    rd_chk("pre_rst_status", 0, 7, 1);
    #2 reset = 1'b1;
    model_clear(0); model_clear(1);
    #1;
    check("arst_rd_valid", rd_valid_a, 0);
    check("arst_rd_data", rd_data_a, 0);
    #2 reset = 1'b0;
    ap_done[0] = 1'b1; step(); ap_done[0] = 1'b0;
    rd_chk("arst_status", 0, 7, 0);
    rd_chk("arst_txn", 0, 0, 0);
    rd_chk("arst_busy", 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hls_handshake_perf_monitor.md
Name: hls_handshake_perf_monitor

Overview:
- Synthesizable, parametrised multi-channel monitor for HLS block-level handshakes (ap_start/ap_ready/ap_done/ap_continue).
- Per channel, records transaction count, busy cycles, continue-stall cycles, overlapped starts, and last/min/max latency.
- Sits beside the accelerator top level and taps each sub-module's control handshake.
- Replaces CSV-only simulation monitoring with counters that can be read back in hardware.

Parameters:
NUM_CH, 4, number of monitored handshake channels (1..16)
CNT_W, 32, width of event and cycle counters
LAT_W, 24, width of latency registers (LAT_W <= CNT_W)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  counting allowed while high (level)
clear  in  1  synchronous clear of all counters and the frozen flag
finish  in  1  end-of-run pulse or level; freezes all counters
ap_start  in  NUM_CH  per-channel ap_start
ap_ready  in  NUM_CH  per-channel ap_ready
ap_done  in  NUM_CH  per-channel ap_done
ap_continue  in  NUM_CH  per-channel ap_continue; tie high for non-dataflow blocks
rd_req  in  1  readout request, single-cycle strobe
rd_ch  in  clog2(NUM_CH) (min 1)  channel select
rd_sel  in  3  0 txn, 1 busy, 2 stall, 3 lat_last, 4 lat_min, 5 lat_max, 6 overlap, 7 status
rd_valid  out  1  high exactly 1 cycle after rd_req
rd_data  out  CNT_W  selected value, zero-extended
frozen  out  1  high once finish has been seen, until clear or reset

Behaviour:
- Reset values: all counters 0, lat_min all-ones (means "no sample"), channel FSMs IDLE, frozen=0, rd_valid=0, rd_data=0.
- Clear has the highest synchronous priority. It writes the reset values in the same edge, and counting restarts on the next cycle.
- Counting is active when enable=1 and frozen=0. Otherwise the FSMs and counters hold their value, and readout still works.
- frozen sets on the edge where finish=1 and is sticky. Events in the cycle finish is high are still counted.
- Per-channel FSM states are IDLE, BUSY and WAIT_CONT. Let D = ap_done & ap_continue, and let lat be the internal running latency.
- IDLE:
  - ap_start=1 and D=1: zero-latency transaction. lat=1 is recorded, txn+1, busy+1, stay IDLE.
  - ap_start=1 and ap_done=1, ap_continue=0: busy+1, stall+1, go to WAIT_CONT.
  - ap_start=1 otherwise: lat<=1, busy+1, go to BUSY.
- BUSY: busy+1, lat+1.
  - D=1: record lat+1 (the count including this cycle) and txn+1. If ap_start=1 in the same cycle, the next transaction begins with lat<=1 and the FSM stays in BUSY. Otherwise go to IDLE.
  - ap_done=1, ap_continue=0: stall+1, go to WAIT_CONT.
  - ap_start & ap_ready & !ap_done: overlap+1; lat keeps tracking the oldest transaction.
- WAIT_CONT: busy+1, lat+1, stall+1 while ap_continue=0.
  - On ap_continue=1: record lat, txn+1, go to IDLE. This cycle is not counted as a stall.
- Record means: lat_last<=value; lat_min<=min(lat_min,value); lat_max<=max(lat_max,value).
- Saturation: every counter and lat saturates at all-ones and never wraps. Saturated lat is recorded as all-ones.
- Readout: rd_data is registered from (rd_ch, rd_sel) on the rd_req edge, with rd_valid the cycle after.
  - rd_ch >= NUM_CH returns 0 with rd_valid still asserted.
  - A read in the same cycle as an update returns the pre-update value.
  - Back-to-back rd_req is allowed, one result per cycle.
- Status word (sel 7): bit[1:0] FSM state (0 IDLE, 1 BUSY, 2 WAIT_CONT), bit2 lat_min valid, bit3 frozen, remaining bits 0.
- Reset asserted mid-transaction: all channels return to IDLE and counters go to 0 immediately, asynchronously. A done arriving after reset release without a start is ignored.
- Channels are fully independent; ap_done in IDLE without ap_start is ignored.

Test Plan:
- Ch0: start at cycle 10, done and continue=1 at cycle 14 -> txn=1, lat_last=lat_min=lat_max=5, busy=5, stall=0.
- Ch1: done at lat 3 with continue low for 4 cycles, then high -> stall=4, lat_last=8, status shows WAIT_CONT during the hold.
- Ch2 pipelined: start&ready held every cycle for 6 cycles, first done at cycle 5 -> overlap counts starts accepted in BUSY without done; txn matches the number of done pulses.
- Two transactions with latencies 7 then 3 -> lat_min=3, lat_max=7, lat_last=3; read with rd_ch=NUM_CH -> rd_data=0, rd_valid=1.
- finish pulse then further traffic -> counters unchanged, frozen=1; clear -> all 0, lat_min all-ones, frozen=0.
- CNT_W=4: 20 transactions -> txn=15 (saturated); reset mid-BUSY -> status=IDLE, all counters 0.
